// File: rtl/forwarding_arbiter.sv
// Forwarding arbiter: per-ingress lookup/ready/forward sequencing with
// round-robin MAC lookup issue and round-robin egress frame selection.
module forwarding_arbiter #(
  parameter int NUM_PORTS      = 15,
  parameter int LOOKUP_LATENCY = 4,
  parameter int COUNT_WIDTH    = 32,
  localparam int PORT_BITS     = $clog2(NUM_PORTS)
) (
  input  logic                    clk_ram_ctl,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    ingress_ready,
  input  logic [NUM_PORTS*12-1:0] ingress_vlan,
  input  logic [NUM_PORTS*11-1:0] ingress_len,
  output logic                    lookup_en,
  output logic [PORT_BITS-1:0]    lookup_src_port,
  input  logic                    lookup_hit,
  input  logic [PORT_BITS-1:0]    lookup_dst_port,
  input  logic [NUM_PORTS*12-1:0] egress_vlan,
  input  logic [NUM_PORTS-1:0]    egress_trunk,
  input  logic [NUM_PORTS*12-1:0] egress_vlan_min,
  input  logic [NUM_PORTS*12-1:0] egress_vlan_max,
  input  logic [NUM_PORTS-1:0]    egress_space_avail,
  input  logic                    frame_last,
  output logic [NUM_PORTS-1:0]    forward_en,
  output logic [NUM_PORTS-1:0]    frame_port_wr,
  output logic [10:0]             frame_len,
  output logic [11:0]             frame_vlan,
  output logic [COUNT_WIDTH-1:0]  drop_count
);
  localparam int LAST = LOOKUP_LATENCY - 1;

  typedef logic [PORT_BITS-1:0] port_t;
  typedef enum logic [1:0] {
    S_IDLE, S_LOOKUP, S_READY, S_FWD
  } pst_e;

  pst_e                 st     [NUM_PORTS];
  pst_e                 st_nxt [NUM_PORTS];
  port_t                dst_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] bc_q;
  logic [11:0]          vl_q   [NUM_PORTS];
  logic [10:0]          len_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0] mask   [NUM_PORTS];

  logic        sr_v  [LOOKUP_LATENCY];
  port_t       sr_p  [LOOKUP_LATENCY];
  logic [11:0] sr_vl [LOOKUP_LATENCY];

  port_t lk_ptr, fw_ptr, cur_src;
  port_t lk_win, fw_win, cap_p;
  logic [NUM_PORTS-1:0] lk_elig, fw_elig;
  logic lk_go, fw_go, fw_act, cap;

  function automatic port_t inc(port_t p);
    return (p == port_t'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic admits(int i, logic [11:0] v);
    logic [11:0] acc, lo, hi;
    acc = egress_vlan[i*12 +: 12];
    lo  = egress_vlan_min[i*12 +: 12];
    hi  = egress_vlan_max[i*12 +: 12];
    return egress_trunk[i] ? (lo <= v && v <= hi) : (acc == v);
  endfunction

  // Per-source egress mask from the latched lookup result
  always_comb begin
    logic [NUM_PORTS-1:0] adm, uni, self;
    for (int p = 0; p < NUM_PORTS; p++) begin
      adm = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        adm[i] = admits(i, vl_q[p]);
      uni  = NUM_PORTS'(1) << dst_q[p];
      self = NUM_PORTS'(1) << p;
      mask[p] = (bc_q[p] ? adm : (adm & uni)) & ~self;
    end
  end

  // Pointer wins if eligible, otherwise the highest eligible index
  always_comb begin
    lk_elig = '0;
    fw_elig = '0;
    lk_win  = '0;
    fw_win  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      lk_elig[i] = (st[i] == S_IDLE) && ingress_ready[i];
      fw_elig[i] = (st[i] == S_READY) &&
                   ((mask[i] & ~egress_space_avail) == '0);
      if (lk_elig[i]) lk_win = port_t'(i);
      if (fw_elig[i]) fw_win = port_t'(i);
    end
    if (lk_elig[lk_ptr]) lk_win = lk_ptr;
    if (fw_elig[fw_ptr]) fw_win = fw_ptr;
    fw_act = |forward_en;
    lk_go  = |lk_elig;
    fw_go  = (!fw_act || frame_last) && (|fw_elig);
    cap    = sr_v[LAST];
    cap_p  = sr_p[LAST];
  end

  always_comb begin
    st_nxt = st;
    if (lk_go) st_nxt[lk_win] = S_LOOKUP;
    if (cap) st_nxt[cap_p] = S_READY;
    if (fw_act && frame_last) st_nxt[cur_src] = S_IDLE;
    if (fw_go) st_nxt[fw_win] = S_FWD;
  end

  always_ff @(posedge clk_ram_ctl) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++)
        st[i] <= S_IDLE;
      for (int k = 0; k < LOOKUP_LATENCY; k++) begin
        sr_v[k]  <= 1'b0;
        sr_p[k]  <= '0;
        sr_vl[k] <= '0;
      end
      lk_ptr          <= '0;
      fw_ptr          <= '0;
      cur_src         <= '0;
      lookup_en       <= 1'b0;
      lookup_src_port <= '0;
      forward_en      <= '0;
      frame_port_wr   <= '0;
      frame_len       <= '0;
      frame_vlan      <= '0;
      drop_count      <= '0;
    end else begin
      st        <= st_nxt;
      lookup_en <= lk_go;
      if (lk_go) begin
        lookup_src_port <= lk_win;
        lk_ptr          <= inc(lk_win);
      end
      sr_v[0]  <= lookup_en;
      sr_p[0]  <= lookup_src_port;
      sr_vl[0] <= ingress_vlan[int'(lookup_src_port)*12 +: 12];
      for (int k = 1; k < LOOKUP_LATENCY; k++) begin
        sr_v[k]  <= sr_v[k-1];
        sr_p[k]  <= sr_p[k-1];
        sr_vl[k] <= sr_vl[k-1];
      end
      frame_port_wr <= '0;
      if (fw_go) begin
        forward_en    <= NUM_PORTS'(1) << fw_win;
        frame_port_wr <= mask[fw_win];
        frame_len     <= len_q[fw_win];
        frame_vlan    <= vl_q[fw_win];
        cur_src       <= fw_win;
        fw_ptr        <= inc(fw_win);
        if (mask[fw_win] == '0 && !(&drop_count))
          drop_count <= drop_count + 1'b1;
      end else if (fw_act && frame_last) begin
        forward_en <= '0;
      end
    end
  end

  // Result payload; only consulted once the owning port is READY
  always_ff @(posedge clk_ram_ctl) begin
    if (cap) begin
      dst_q[cap_p] <= lookup_dst_port;
      bc_q[cap_p]  <= !lookup_hit;
      vl_q[cap_p]  <= sr_vl[LAST];
      len_q[cap_p] <= ingress_len[int'(cap_p)*11 +: 11];
    end
  end
endmodule

// File: tb/tb_forwarding_arbiter.sv
// Testbench for forwarding_arbiter: directed scenarios plus randomized
// traffic checked every cycle against a behavioural model.
module tb_forwarding_arbiter;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int PB = 2;
  localparam int CW = 32;

  logic clk_ram_ctl = 1'b0;
  logic rst;
  logic [N-1:0]    ingress_ready;
  logic [N*12-1:0] ingress_vlan;
  logic [N*11-1:0] ingress_len;
  logic            lookup_en;
  logic [PB-1:0]   lookup_src_port;
  logic            lookup_hit;
  logic [PB-1:0]   lookup_dst_port;
  logic [N*12-1:0] egress_vlan, egress_vlan_min, egress_vlan_max;
  logic [N-1:0]    egress_trunk, egress_space_avail;
  logic            frame_last;
  logic [N-1:0]    forward_en, frame_port_wr;
  logic [10:0]     frame_len;
  logic [11:0]     frame_vlan;
  logic [CW-1:0]   drop_count;

  always #5 clk_ram_ctl = ~clk_ram_ctl;

  forwarding_arbiter #(
    .NUM_PORTS(N), .LOOKUP_LATENCY(L), .COUNT_WIDTH(CW)
  ) dut (
    .clk_ram_ctl(clk_ram_ctl), .rst(rst),
    .ingress_ready(ingress_ready), .ingress_vlan(ingress_vlan),
    .ingress_len(ingress_len), .lookup_en(lookup_en),
    .lookup_src_port(lookup_src_port), .lookup_hit(lookup_hit),
    .lookup_dst_port(lookup_dst_port), .egress_vlan(egress_vlan),
    .egress_trunk(egress_trunk), .egress_vlan_min(egress_vlan_min),
    .egress_vlan_max(egress_vlan_max),
    .egress_space_avail(egress_space_avail), .frame_last(frame_last),
    .forward_en(forward_en), .frame_port_wr(frame_port_wr),
    .frame_len(frame_len), .frame_vlan(frame_vlan),
    .drop_count(drop_count)
  );

  typedef struct {
    int port;
    int due;
    bit hit;
    int dst;
  } pend_t;

  pend_t pend[$];
  int mst[N];
  int m_lk_ptr, m_fw_ptr, m_cur;
  int m_dst[N], m_vl[N], m_len[N];
  bit m_bc[N];
  bit [N-1:0] e_fwd, e_pwr;
  bit e_lk_en;
  int e_lk_src, e_len, e_vlan;
  longint e_drop;
  bit tbl_hit[N];
  int tbl_dst[N];
  bit rand_tbl;
  int cyc, n_vec, n_bad;
  int vls[4] = '{10, 20, 30, 40};

  function automatic bit admits(int i, int v);
    if (egress_trunk[i])
      return v >= int'(egress_vlan_min[i*12 +: 12]) &&
             v <= int'(egress_vlan_max[i*12 +: 12]);
    return v == int'(egress_vlan[i*12 +: 12]);
  endfunction

  // Set of destinations: every other admitting port (broadcast) or the one hit
  function automatic bit [N-1:0] mask_of(int p);
    bit [N-1:0] m = '0;
    for (int i = 0; i < N; i++)
      if (i != p && admits(i, m_vl[p]) && (m_bc[p] || m_dst[p] == i))
        m[i] = 1'b1;
    return m;
  endfunction

  function automatic int pick(bit [N-1:0] e, int ptr);
    if (e[ptr]) return ptr;
    for (int i = N - 1; i >= 0; i--)
      if (e[i]) return i;
    return -1;
  endfunction

  function automatic void model_step();
    bit [N-1:0] le, fe, m;
    int w, s;
    bit act;
    if (rst) begin
      foreach (mst[i]) mst[i] = 0;
      m_lk_ptr = 0; m_fw_ptr = 0; m_cur = 0;
      e_fwd = '0; e_pwr = '0; e_lk_en = 0; e_lk_src = 0;
      e_len = 0; e_vlan = 0; e_drop = 0;
      pend.delete();
      return;
    end
    for (int i = 0; i < N; i++) begin
      le[i] = mst[i] == 0 && ingress_ready[i];
      fe[i] = mst[i] == 2 && (mask_of(i) & ~egress_space_avail) == '0;
    end
    act = e_fwd != '0;
    w = pick(le, m_lk_ptr);
    s = (!act || frame_last) ? pick(fe, m_fw_ptr) : -1;
    e_pwr = '0;
    if (act && frame_last) begin
      mst[m_cur] = 0;
      e_fwd = '0;
    end
    if (s >= 0) begin
      m = mask_of(s);
      e_fwd = '0;
      e_fwd[s] = 1'b1;
      e_pwr = m;
      e_len = m_len[s];
      e_vlan = m_vl[s];
      m_cur = s;
      m_fw_ptr = (s + 1) % N;
      mst[s] = 3;
      if (m == '0 && e_drop < 64'hFFFF_FFFF) e_drop++;
    end
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].due == cyc) begin
        mst[pend[k].port] = 2;
        m_dst[pend[k].port] = pend[k].dst;
        m_bc[pend[k].port] = !pend[k].hit;
        m_vl[pend[k].port] = int'(ingress_vlan[pend[k].port*12 +: 12]);
        m_len[pend[k].port] = int'(ingress_len[pend[k].port*11 +: 11]);
        pend.delete(k);
      end
    end
    e_lk_en = w >= 0;
    if (w >= 0) begin
      mst[w] = 1;
      e_lk_src = w;
      m_lk_ptr = (w + 1) % N;
      if (rand_tbl) begin
        tbl_hit[w] = 1'($urandom);
        tbl_dst[w] = int'($urandom_range(0, N - 1));
      end
      pend.push_back('{w, cyc + 1 + L, tbl_hit[w], tbl_dst[w]});
    end
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void compare();
    chk("lookup_en", 64'(lookup_en), 64'(e_lk_en));
    chk("lookup_src_port", 64'(lookup_src_port), 64'(e_lk_src));
    chk("forward_en", 64'(forward_en), 64'(e_fwd));
    chk("frame_port_wr", 64'(frame_port_wr), 64'(e_pwr));
    chk("frame_len", 64'(frame_len), 64'(e_len));
    chk("frame_vlan", 64'(frame_vlan), 64'(e_vlan));
    chk("drop_count", 64'(drop_count), 64'(e_drop));
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_ram_ctl);
    #1;
    cyc++;
    compare();
    lookup_hit = 1'($urandom);
    lookup_dst_port = PB'($urandom);
    foreach (pend[k])
      if (pend[k].due == cyc) begin
        lookup_hit = pend[k].hit;
        lookup_dst_port = PB'(pend[k].dst);
      end
  endtask

  task automatic wait_fwd(output int k);
    k = 0;
    while (forward_en == '0 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (forward_en == '0) begin
      n_bad++;
      $display("FAIL wait_fwd: got no forward_en after %0d cycles", k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ingress_ready = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_last();
    frame_last = 1'b1;
    tick();
    frame_last = 1'b0;
  endtask

  function automatic void set_access(int p, int v);
    egress_trunk[p] = 1'b0;
    egress_vlan[p*12 +: 12] = 12'(v);
  endfunction

  function automatic void set_ingress(int p, int v, int len);
    ingress_vlan[p*12 +: 12] = 12'(v);
    ingress_len[p*11 +: 11] = 11'(len);
  endfunction

  initial begin
    int k;
    n_vec = 0; n_bad = 0; cyc = 0; rand_tbl = 0;
    ingress_ready = '0; ingress_vlan = '0; ingress_len = '0;
    lookup_hit = 0; lookup_dst_port = '0;
    egress_vlan = '0; egress_vlan_min = '0; egress_vlan_max = '0;
    egress_trunk = '0; egress_space_avail = '1; frame_last = 0;
    foreach (tbl_hit[i]) begin tbl_hit[i] = 0; tbl_dst[i] = 0; end
    do_reset();
    chk("rst_lookup_en", 64'(lookup_en), 0);
    chk("rst_forward_en", 64'(forward_en), 0);
    chk("rst_port_wr", 64'(frame_port_wr), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_len_vlan", 64'({frame_len, frame_vlan}), 0);

    // Lookup round-robin: ports 1 and 3 together
    ingress_ready = 4'b1010;
    tick();
    chk("rr_first", 64'({lookup_en, lookup_src_port}), 64'({1'b1, 2'd3}));
    tick();
    chk("rr_second", 64'({lookup_en, lookup_src_port}), 64'({1'b1, 2'd1}));
    ingress_ready = 4'b0101;
    tick();
    chk("rr_ptr2", 64'(lookup_src_port), 2);
    ingress_ready = '0;
    repeat (12) tick();
    do_reset();

    // Unicast 0 -> 2 on access VLAN 10
    set_access(0, 10); set_access(1, 20);
    set_access(2, 10); set_access(3, 30);
    set_ingress(0, 10, 100);
    tbl_hit[0] = 1; tbl_dst[0] = 2;
    ingress_ready = 4'b0001;
    tick();
    ingress_ready = '0;
    wait_fwd(k);
    chk("uni_latency", 64'(k), 6);
    chk("uni_port_wr", 64'(frame_port_wr), 4'b0100);
    chk("uni_fwd", 64'(forward_en), 4'b0001);
    chk("uni_len_vlan", 64'({frame_len, frame_vlan}), 64'({11'd100, 12'd10}));
    tick();
    chk("uni_wr_once", 64'({forward_en, frame_port_wr}), 64'({4'b0001, 4'b0000}));
    pulse_last();
    chk("uni_end", 64'(forward_en), 0);

    // Broadcast from port 0 on VLAN 20 with a trunk
    set_access(0, 20); set_access(1, 20); set_access(2, 30);
    egress_trunk[3] = 1'b1;
    egress_vlan_min[36 +: 12] = 12'd1;
    egress_vlan_max[36 +: 12] = 12'd100;
    set_ingress(0, 20, 64);
    tbl_hit[0] = 0;
    ingress_ready = 4'b0001;
    tick();
    ingress_ready = '0;
    wait_fwd(k);
    chk("bc_port_wr", 64'(frame_port_wr), 4'b1010);
    pulse_last();

    // Unicast back to the source drains and counts a drop
    chk("drop_before", 64'(drop_count), 0);
    set_access(2, 10);
    set_ingress(2, 10, 200);
    tbl_hit[2] = 1; tbl_dst[2] = 2;
    ingress_ready = 4'b0100;
    tick();
    ingress_ready = '0;
    wait_fwd(k);
    chk("self_fwd", 64'(forward_en), 4'b0100);
    chk("self_wr", 64'(frame_port_wr), 0);
    chk("self_drop", 64'(drop_count), 1);
    pulse_last();

    // Back-to-back frames and space back-pressure
    do_reset();
    for (int p = 0; p < N; p++) set_access(p, 10);
    set_ingress(0, 10, 300); set_ingress(1, 10, 400);
    tbl_hit[0] = 1; tbl_dst[0] = 2;
    tbl_hit[1] = 1; tbl_dst[1] = 3;
    egress_space_avail = 4'b0011;
    ingress_ready = 4'b0011;
    tick();
    tick();
    ingress_ready = '0;
    repeat (12) tick();
    chk("space_hold", 64'(forward_en), 0);
    egress_space_avail[2] = 1'b1;
    wait_fwd(k);
    chk("b2b_first", 64'(forward_en), 4'b0001);
    egress_space_avail[3] = 1'b1;
    tick();
    tick();
    pulse_last();
    chk("b2b_second", 64'(forward_en), 4'b0010);
    chk("b2b_wr", 64'(frame_port_wr), 4'b1000);
    pulse_last();

    // Reset mid-frame with a lookup in flight
    ingress_ready = 4'b0001;
    tick();
    ingress_ready = '0;
    wait_fwd(k);
    ingress_ready = 4'b0010;
    tick();
    ingress_ready = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_fwd", 64'({lookup_en, forward_en, frame_port_wr}), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_quiet", 64'({forward_en, frame_port_wr}), 0);
    end

    // Randomized traffic
    rand_tbl = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0)
        for (int p = 0; p < N; p++) begin
          egress_vlan[p*12 +: 12] = 12'(vls[$urandom_range(0, 2)]);
          egress_trunk[p] = ($urandom_range(0, 2) == 0);
          egress_vlan_min[p*12 +: 12] = 12'($urandom_range(1, 25));
          egress_vlan_max[p*12 +: 12] =
            egress_vlan_min[p*12 +: 12] + 12'($urandom_range(0, 20));
        end
      ingress_ready = N'($urandom);
      for (int p = 0; p < N; p++)
        if (mst[p] == 0)
          set_ingress(p, vls[$urandom_range(0, 3)], int'($urandom_range(0, 2047)));
      egress_space_avail = N'($urandom | $urandom);
      frame_last = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    frame_last = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
